// File: rtl/lc3b_types.sv
// Shared LC-3b types for the MEM stage: data word, register index,
// MEM control word and the MEM-stage FSM encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_byte;
        logic mem_indirect;
    } lc3b_control_word_mem;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IND_READ = 2'd1,
        ACCESS   = 2'd2
    } mem_state_t;

    localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for data memory: store-side lane enables and data
// replication, load-side byte select with zero extension.
module mem_byte_align
    import lc3b_types::*;
(
    input  logic       byte_mode,
    input  logic       addr_lsb,
    input  lc3b_word   wdata_in,
    input  lc3b_word   rdata,
    output logic [1:0] byte_enable,
    output lc3b_word   wdata,
    output lc3b_word   load_data
);

    always_comb begin
        byte_enable = BE_WORD;
        wdata       = wdata_in;
        load_data   = rdata;
        if (byte_mode) begin
            // Store byte is replicated so memory can take either lane.
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
            wdata       = {wdata_in[7:0], wdata_in[7:0]};
            load_data   = {8'h00, (addr_lsb ? rdata[15:8] : rdata[7:0])};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: drives the data-memory handshake for word, byte and
// indirect accesses, stalls upstream until completion, counts stall cycles.
module mem_stage
    import lc3b_types::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   valid_in,
    input  lc3b_control_word_mem   mem_sig_in,
    input  lc3b_word               mar_in,
    input  lc3b_word               mdr_in,
    output lc3b_word               dmem_address,
    output lc3b_word               dmem_wdata,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [1:0]             dmem_byte_enable,
    input  lc3b_word               dmem_rdata,
    input  logic                   dmem_resp,
    output lc3b_word               mem_data_out,
    output logic                   valid_out,
    output logic                   stall_out,
    input  logic                   stall_cnt_clr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    mem_state_t state;
    lc3b_word   ind_addr;
    logic       mop;
    logic [1:0] align_be;
    lc3b_word   align_wdata;
    lc3b_word   align_load;

    assign mop = valid_in & (mem_sig_in.mem_read | mem_sig_in.mem_write);

    // Indirect accesses are always word-wide, so mem_byte is masked there.
    mem_byte_align u_align (
        .byte_mode   (mem_sig_in.mem_byte & ~mem_sig_in.mem_indirect),
        .addr_lsb    (mar_in[0]),
        .wdata_in    (mdr_in),
        .rdata       (dmem_rdata),
        .byte_enable (align_be),
        .wdata       (align_wdata),
        .load_data   (align_load)
    );

    always_comb begin
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = 2'b00;
        mem_data_out     = '0;
        stall_out        = 1'b0;
        case (state)
            IDLE: begin
                stall_out = mop;
            end
            IND_READ: begin
                dmem_read        = 1'b1;
                dmem_address     = mar_in;
                dmem_byte_enable = BE_WORD;
                stall_out        = 1'b1;
            end
            ACCESS: begin
                dmem_address     = mem_sig_in.mem_indirect ? ind_addr : mar_in;
                dmem_wdata       = align_wdata;
                dmem_byte_enable = align_be;
                dmem_read        = mem_sig_in.mem_read;
                // Read+write together is treated as a read.
                dmem_write       = mem_sig_in.mem_write & ~mem_sig_in.mem_read;
                stall_out        = ~dmem_resp;
                if (dmem_resp) begin
                    mem_data_out = align_load;
                end
            end
            default: ;
        endcase
    end

    assign valid_out = valid_in & ~stall_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ind_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mop) begin
                        state <= mem_sig_in.mem_indirect ? IND_READ : ACCESS;
                    end
                end
                IND_READ: begin
                    if (dmem_resp) begin
                        ind_addr <= dmem_rdata;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // EX/MEM advances on this same edge, so IDLE sees the next op.
                    if (dmem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_out && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule
